pc_sequencer: RTL and testbench

Control FSM that sequences module_PC from a small command interface. It turns CLEAR/STEP/JUMP/RUN commands into the PC's 2-bit operation code and jump address. RUN mode paces increments with a prescaler so PC progress is visible on board LEDs, and can stop on a breakpoint or an abort. It sits between the switch/button logic and module_PC, in the 10 MHz PLL domain.

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Command sequencer for module_PC: turns CLEAR/STEP/JUMP/RUN requests into
// PC operation codes, with paced RUN mode, breakpoint and abort.
//
// state    | meaning
// ---------+--------------------------------------------------
// INIT     | first cycle after reset, PC held cleared
// IDLE     | ready for a command, PC held
// CLEAR    | drives clear to the PC for one cycle
// STEP     | drives one increment
// JUMP     | drives load of pc_addr_o
// RUN_WAIT | prescaler pacing, breakpoint checked on last tick
// RUN_INC  | drives one paced increment
// DONE     | completion pulse, PC held
module pc_sequencer #(
  parameter int ANCHO = 4,
  parameter int CNT_W = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [ANCHO-1:0] cmd_addr_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             abort_i,
  input  logic             brk_en_i,
  input  logic [ANCHO-1:0] brk_addr_i,
  input  logic [ANCHO-1:0] pc_value_i,
  output logic [1:0]       pc_op_o,
  output logic [ANCHO-1:0] pc_addr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             brk_hit_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  localparam int TICK_W = $clog2(DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 2);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CLEAR, S_STEP, S_JUMP, S_RUN_WAIT, S_RUN_INC, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [1:0]         pc_op_d;
  logic [ANCHO-1:0]   pc_addr_d;
  logic [CNT_W-1:0]   step_d;
  logic               brk_d;
  logic               accept;

  assign accept = cmd_ready_o && cmd_valid_i;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    n_d       = n_q;
    pc_addr_d = pc_addr_o;
    step_d    = step_cnt_o;
    brk_d     = brk_hit_o;
    pc_op_d   = 2'b01;

    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          n_d    = cmd_count_i;
          step_d = '0;
          brk_d  = 1'b0;
          case (cmd_op_i)
            2'b00: state_d = S_CLEAR;
            2'b01: state_d = S_STEP;
            2'b10: begin
              pc_addr_d = cmd_addr_i;
              state_d   = S_JUMP;
            end
            default: begin
              tick_d  = '0;
              state_d = (cmd_count_i == '0) ? S_DONE : S_RUN_WAIT;
            end
          endcase
        end
      end
      S_CLEAR, S_STEP, S_JUMP: state_d = S_DONE;
      S_RUN_WAIT: begin
        // pc_value_i has settled from the previous increment by the last tick
        if (abort_i) begin
          state_d = S_DONE;
        end else if (tick_q == TICK_LAST) begin
          if (brk_en_i && (pc_value_i == brk_addr_i)) begin
            brk_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN_INC;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_RUN_INC: begin
        if (abort_i || (step_cnt_o == n_q)) begin
          state_d = S_DONE;
        end else begin
          tick_d  = '0;
          state_d = S_RUN_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    if ((state_d == S_STEP) || (state_d == S_RUN_INC))
      step_d = step_d + CNT_W'(1);

    case (state_d)
      S_INIT, S_CLEAR:   pc_op_d = 2'b00;
      S_STEP, S_RUN_INC: pc_op_d = 2'b10;
      S_JUMP:            pc_op_d = 2'b11;
      default:           pc_op_d = 2'b01;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      tick_q      <= '0;
      n_q         <= '0;
      pc_op_o     <= 2'b00;
      pc_addr_o   <= '0;
      cmd_ready_o <= 1'b0;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      brk_hit_o   <= 1'b0;
      step_cnt_o  <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      n_q         <= n_d;
      pc_op_o     <= pc_op_d;
      pc_addr_o   <= pc_addr_d;
      cmd_ready_o <= (state_d == S_IDLE);
      busy_o      <= (state_d != S_IDLE);
      done_o      <= (state_d == S_DONE);
      brk_hit_o   <= brk_d;
      step_cnt_o  <= step_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, with a behavioural module_PC
// model closing the loop on pc_value_i.
module tb_pc_sequencer;

  localparam int ANCHO = 4;
  localparam int CNT_W = 8;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [1:0]       cmd_op_i = 2'b00;
  logic [ANCHO-1:0] cmd_addr_i = '0;
  logic [CNT_W-1:0] cmd_count_i = '0;
  logic             abort_i = 1'b0;
  logic             brk_en_i = 1'b0;
  logic [ANCHO-1:0] brk_addr_i = '0;
  logic [ANCHO-1:0] pc_value_i;
  logic [1:0]       pc_op_o;
  logic [ANCHO-1:0] pc_addr_o;
  logic             busy_o;
  logic             done_o;
  logic             brk_hit_o;
  logic [CNT_W-1:0] step_cnt_o;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(.ANCHO(ANCHO), .CNT_W(CNT_W), .DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_count_i(cmd_count_i),
    .abort_i(abort_i), .brk_en_i(brk_en_i), .brk_addr_i(brk_addr_i),
    .pc_value_i(pc_value_i), .pc_op_o(pc_op_o), .pc_addr_o(pc_addr_o),
    .busy_o(busy_o), .done_o(done_o), .brk_hit_o(brk_hit_o),
    .step_cnt_o(step_cnt_o)
  );

  always #50 clk = ~clk;

  // module_PC model: clear / hold / +4 / load
  logic [ANCHO-1:0] pc_model;
  always @(posedge clk or posedge reset) begin
    if (reset) pc_model <= '0;
    else case (pc_op_o)
      2'b00:   pc_model <= '0;
      2'b10:   pc_model <= pc_model + ANCHO'(4);
      2'b11:   pc_model <= pc_addr_o;
      default: pc_model <= pc_model;
    endcase
  end
  assign pc_value_i = pc_model;

  typedef struct {
    logic [1:0]       op;
    logic [ANCHO-1:0] addr;
    logic [CNT_W-1:0] count;
    logic             brk_en;
    logic [ANCHO-1:0] brk_addr;
    int               abort_at;
    int               exp_done;
    int               exp_incs;
    int               exp_step;
    int               exp_brk;
    int               exp_pc;
    int               exp_paddr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_inc_cycle(input logic [1:0] op, input int i);
    return (op == 2'b01) ? 0 : (DIV - 1) + DIV * i;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, " pc_op"},    int'(pc_op_o), 0);
    chk({tag, " ready"},    int'(cmd_ready_o), 0);
    chk({tag, " busy"},     int'(busy_o), 1);
    chk({tag, " done"},     int'(done_o), 0);
    chk({tag, " brk_hit"},  int'(brk_hit_o), 0);
    chk({tag, " step_cnt"}, int'(step_cnt_o), 0);
    chk({tag, " pc_addr"},  int'(pc_addr_o), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle pc_op"}, int'(pc_op_o), 1);
    chk({tag, " idle ready"}, int'(cmd_ready_o), 1);
    chk({tag, " idle busy"},  int'(busy_o), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    n_incs, t_err, b_err, done_cyc;
    string tag;
    tag      = $sformatf("vec%0d", idx);
    n_incs   = 0;
    t_err    = 0;
    b_err    = 0;
    done_cyc = -1;
    @(negedge clk);
    chk({tag, " ready"}, int'(cmd_ready_o), 1);
    cmd_op_i    = v.op;
    cmd_addr_i  = v.addr;
    cmd_count_i = v.count;
    brk_en_i    = v.brk_en;
    brk_addr_i  = v.brk_addr;
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (pc_op_o == 2'b10) begin
        if (k != exp_inc_cycle(v.op, n_incs)) t_err++;
        n_incs++;
      end
      if (!busy_o || cmd_ready_o) b_err++;
      if (done_o) begin
        done_cyc = k;
        break;
      end
      abort_i = (k == v.abort_at);
      if (k >= 1) cmd_valid_i = 1'b0;
    end
    cmd_valid_i = 1'b0;
    abort_i     = 1'b0;
    chk({tag, " done_cycle"},  done_cyc, v.exp_done);
    chk({tag, " inc_count"},   n_incs, v.exp_incs);
    chk({tag, " inc_timing"},  t_err, 0);
    chk({tag, " busy_window"}, b_err, 0);
    chk({tag, " step_cnt"},    int'(step_cnt_o), v.exp_step);
    chk({tag, " brk_hit"},     int'(brk_hit_o), v.exp_brk);
    chk({tag, " pc"},          int'(pc_value_i), v.exp_pc);
    chk({tag, " pc_addr"},     int'(pc_addr_o), v.exp_paddr);
  endtask

  initial begin
    //           op     addr  cnt    be    ba   abort done incs step brk pc  paddr
    vecs[0]  = '{2'b01, 4'h0, 8'd0,  1'b0, 4'h0, -1,  1,   1,   1,   0,  4,  0};
    vecs[1]  = '{2'b10, 4'hA, 8'd0,  1'b0, 4'h0, -1,  1,   0,   0,   0,  10, 10};
    vecs[2]  = '{2'b00, 4'h5, 8'd0,  1'b0, 4'h0, -1,  1,   0,   0,   0,  0,  10};
    vecs[3]  = '{2'b11, 4'h0, 8'd3,  1'b0, 4'h0, -1,  12,  3,   3,   0,  12, 10};
    vecs[4]  = '{2'b00, 4'h0, 8'd0,  1'b0, 4'h0, -1,  1,   0,   0,   0,  0,  10};
    vecs[5]  = '{2'b11, 4'h0, 8'd5,  1'b1, 4'h8, -1,  11,  2,   2,   1,  8,  10};
    vecs[6]  = '{2'b00, 4'h0, 8'd0,  1'b0, 4'h0, -1,  1,   0,   0,   0,  0,  10};
    vecs[7]  = '{2'b11, 4'h0, 8'd5,  1'b1, 4'h0, -1,  3,   0,   0,   1,  0,  10};
    vecs[8]  = '{2'b11, 4'h0, 8'd0,  1'b1, 4'h0, -1,  0,   0,   0,   0,  0,  10};
    vecs[9]  = '{2'b11, 4'h0, 8'd10, 1'b0, 4'h0, 8,   9,   2,   2,   0,  8,  10};
    vecs[10] = '{2'b11, 4'h0, 8'd10, 1'b0, 4'h0, 7,   8,   2,   2,   0,  0,  10};
    vecs[11] = '{2'b11, 4'h0, 8'd10, 1'b1, 4'h0, 2,   3,   0,   0,   0,  0,  10};
    vecs[12] = '{2'b01, 4'h0, 8'd0,  1'b1, 4'h0, 0,   1,   1,   1,   0,  4,  10};
    vecs[13] = '{2'b11, 4'h0, 8'd2,  1'b0, 4'h0, -1,  8,   2,   2,   0,  12, 10};

    // reset state and the single INIT cycle
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("init pc_op", int'(pc_op_o), 0);
    chk("init busy",  int'(busy_o), 1);
    @(negedge clk);
    check_idle("post_reset");
    chk("post_reset step_cnt", int'(step_cnt_o), 0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // reset in the middle of a RUN
    @(negedge clk);
    check_idle("pre_midrun");
    cmd_op_i    = 2'b11;
    cmd_count_i = 8'd10;
    brk_en_i    = 1'b0;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun step_before", int'(step_cnt_o), 1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("midrun");
    begin
      int d_seen;
      d_seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done_o) d_seen++;
      end
      chk("midrun no_done", d_seen, 0);
    end
    reset = 1'b0;
    #1;
    chk("midrun init pc_op", int'(pc_op_o), 0);
    @(negedge clk);
    check_idle("midrun_release");
    chk("midrun_release step_cnt", int'(step_cnt_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
